// File: rtl/rename_register_file_pkg.sv
// Shared constants and types for the rename register file slice.
// Holds the default RoB tag width and the architectural register geometry.
package rename_register_file_pkg;

  localparam int ROB_WIDTH_BIT = 4;
  localparam int REG_COUNT     = 32;
  localparam int REG_ID_BIT    = 5;
  localparam int DATA_BIT      = 32;

  typedef logic [DATA_BIT-1:0]   word_t;
  typedef logic [REG_ID_BIT-1:0] reg_id_t;

endpackage

// File: rtl/rename_register_file_operand_resolver.sv
// Resolves one source operand to a value or to a pending RoB producer tag.
// Priority: x0, idle register, same-cycle commit bypass, RoB result, still pending.
module operand_resolver
  import rename_register_file_pkg::*;
#(
  parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
  input  logic [REG_ID_BIT-1:0]   reg_id_i,
  input  logic [DATA_BIT-1:0]     value_i,
  input  logic                    busy_i,
  input  logic [ROB_SIZE_BIT-1:0] tag_i,
  input  logic [REG_ID_BIT-1:0]   commit_id_i,
  input  logic [ROB_SIZE_BIT-1:0] commit_tag_i,
  input  logic [DATA_BIT-1:0]     commit_val_i,
  input  logic                    rob_ready_i,
  input  logic [DATA_BIT-1:0]     rob_value_i,
  output logic [DATA_BIT-1:0]     val_o,
  output logic                    has_dep_o,
  output logic [ROB_SIZE_BIT-1:0] dep_o
);

  always_comb begin
    val_o     = '0;
    has_dep_o = 1'b0;
    dep_o     = '0;
    if (reg_id_i == '0) begin
      val_o = '0;
    end else if (!busy_i) begin
      val_o = value_i;
    end else if ((commit_id_i == reg_id_i) && (commit_tag_i == tag_i)) begin
      val_o = commit_val_i;
    end else if (rob_ready_i) begin
      val_o = rob_value_i;
    end else begin
      has_dep_o = 1'b1;
      dep_o     = tag_i;
    end
  end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with rename state (busy + producer tag) per register.
// Two combinational read ports resolve operands; commit/dep updates land on the next edge.
module rename_register_file
  import rename_register_file_pkg::*;
#(
  parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic [REG_ID_BIT-1:0]   set_reg_id,
  input  logic [DATA_BIT-1:0]     set_val,
  input  logic [ROB_SIZE_BIT-1:0] set_reg_on_rob_id,
  input  logic [REG_ID_BIT-1:0]   set_dep_reg_id,
  input  logic [ROB_SIZE_BIT-1:0] set_dep_rob_id,
  input  logic [REG_ID_BIT-1:0]   get_id1,
  input  logic [REG_ID_BIT-1:0]   get_id2,
  output logic [DATA_BIT-1:0]     val1,
  output logic [DATA_BIT-1:0]     val2,
  output logic                    has_dep1,
  output logic                    has_dep2,
  output logic [ROB_SIZE_BIT-1:0] dep1,
  output logic [ROB_SIZE_BIT-1:0] dep2,
  output logic [ROB_SIZE_BIT-1:0] get_rob_id1,
  output logic [ROB_SIZE_BIT-1:0] get_rob_id2,
  input  logic                    rob_value1_ready,
  input  logic                    rob_value2_ready,
  input  logic [DATA_BIT-1:0]     rob_value1,
  input  logic [DATA_BIT-1:0]     rob_value2
);

  logic [DATA_BIT-1:0]     value_arr [REG_COUNT];
  logic                    busy_arr  [REG_COUNT];
  logic [ROB_SIZE_BIT-1:0] tag_arr   [REG_COUNT];

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 is hardwired: never written, never renamed.
        assign value_arr[gi] = '0;
        assign busy_arr[gi]  = 1'b0;
        assign tag_arr[gi]   = '0;
      end else begin : g_live
        logic [DATA_BIT-1:0]     value_q, value_d;
        logic                    busy_q,  busy_d;
        logic [ROB_SIZE_BIT-1:0] tag_q,   tag_d;
        logic                    commit_hit, dep_hit;

        assign commit_hit = (set_reg_id == REG_ID_BIT'(gi));
        assign dep_hit    = (set_dep_reg_id == REG_ID_BIT'(gi));

        always_comb begin
          value_d = value_q;
          busy_d  = busy_q;
          tag_d   = tag_q;
          if (clear) begin
            busy_d = 1'b0;
          end else begin
            if (commit_hit) begin
              value_d = set_val;
              if (busy_q && (tag_q == set_reg_on_rob_id)) begin
                busy_d = 1'b0;
              end
            end
            // A new producer overrides any release from the same-cycle commit.
            if (dep_hit) begin
              busy_d = 1'b1;
              tag_d  = set_dep_rob_id;
            end
          end
        end

        always_ff @(posedge clk_in or posedge rst_in) begin
          if (rst_in) begin
            value_q <= '0;
            busy_q  <= 1'b0;
            tag_q   <= '0;
          end else if (rdy_in) begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
          end
        end

        assign value_arr[gi] = value_q;
        assign busy_arr[gi]  = busy_q;
        assign tag_arr[gi]   = tag_q;
      end
    end
  endgenerate

  assign get_rob_id1 = tag_arr[get_id1];
  assign get_rob_id2 = tag_arr[get_id2];

  operand_resolver #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_res1 (
    .reg_id_i     (get_id1),
    .value_i      (value_arr[get_id1]),
    .busy_i       (busy_arr[get_id1]),
    .tag_i        (tag_arr[get_id1]),
    .commit_id_i  (set_reg_id),
    .commit_tag_i (set_reg_on_rob_id),
    .commit_val_i (set_val),
    .rob_ready_i  (rob_value1_ready),
    .rob_value_i  (rob_value1),
    .val_o        (val1),
    .has_dep_o    (has_dep1),
    .dep_o        (dep1)
  );

  operand_resolver #(.ROB_SIZE_BIT(ROB_SIZE_BIT)) u_res2 (
    .reg_id_i     (get_id2),
    .value_i      (value_arr[get_id2]),
    .busy_i       (busy_arr[get_id2]),
    .tag_i        (tag_arr[get_id2]),
    .commit_id_i  (set_reg_id),
    .commit_tag_i (set_reg_on_rob_id),
    .commit_val_i (set_val),
    .rob_ready_i  (rob_value2_ready),
    .rob_value_i  (rob_value2),
    .val_o        (val2),
    .has_dep_o    (has_dep2),
    .dep_o        (dep2)
  );

endmodule

// File: tb/tb_rename_register_file.sv
// Directed scoreboard bench for rename_register_file: stimulus pushes expectations,
// a negedge monitor pops and compares them against the read ports.
module tb_rename_register_file;

  localparam int RB = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear;
  logic [4:0]    set_reg_id;
  logic [31:0]   set_val;
  logic [RB-1:0] set_reg_on_rob_id;
  logic [4:0]    set_dep_reg_id;
  logic [RB-1:0] set_dep_rob_id;
  logic [4:0]    get_id1, get_id2;
  logic [31:0]   val1, val2;
  logic          has_dep1, has_dep2;
  logic [RB-1:0] dep1, dep2;
  logic [RB-1:0] get_rob_id1, get_rob_id2;
  logic          rob_value1_ready, rob_value2_ready;
  logic [31:0]   rob_value1, rob_value2;

  rename_register_file #(.ROB_SIZE_BIT(RB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
    .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
    .get_id1(get_id1), .get_id2(get_id2),
    .val1(val1), .val2(val2), .has_dep1(has_dep1), .has_dep2(has_dep2),
    .dep1(dep1), .dep2(dep2), .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .rob_value1_ready(rob_value1_ready), .rob_value2_ready(rob_value2_ready),
    .rob_value1(rob_value1), .rob_value2(rob_value2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int            port;
    string         name;
    logic [31:0]   val;
    logic          hd;
    logic [RB-1:0] dep;
    logic [RB-1:0] rid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_port(input int port, input string name, input logic [31:0] v,
                             input logic hd, input logic [RB-1:0] d, input logic [RB-1:0] r);
    exp_t e;
    e.port = port; e.name = name; e.val = v; e.hd = hd; e.dep = d; e.rid = r;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0;
    set_reg_id = '0; set_val = '0; set_reg_on_rob_id = '0;
    set_dep_reg_id = '0; set_dep_rob_id = '0;
    get_id1 = '0; get_id2 = '0;
    rob_value1_ready = 1'b0; rob_value2_ready = 1'b0;
    rob_value1 = '0; rob_value2 = '0;
  endtask

  // Monitor: the read ports are always presenting, so drain the queue each negedge.
  initial begin
    forever begin
      @(negedge clk_in);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0]   a_val;
        logic          a_hd;
        logic [RB-1:0] a_dep, a_rid;
        e = exp_q.pop_front();
        if (e.port == 1) begin
          a_val = val1; a_hd = has_dep1; a_dep = dep1; a_rid = get_rob_id1;
        end else begin
          a_val = val2; a_hd = has_dep2; a_dep = dep2; a_rid = get_rob_id2;
        end
        checks++;
        if ({a_val, a_hd, a_dep, a_rid} !== {e.val, e.hd, e.dep, e.rid}) begin
          errors++;
          $display("FAIL %s port%0d: got val=%h has_dep=%b dep=%0d rob_id=%0d, want val=%h has_dep=%b dep=%0d rob_id=%0d",
                   e.name, e.port, a_val, a_hd, a_dep, a_rid, e.val, e.hd, e.dep, e.rid);
        end else begin
          $display("ok   %s port%0d: val=%h has_dep=%b dep=%0d rob_id=%0d",
                   e.name, e.port, a_val, a_hd, a_dep, a_rid);
        end
      end
    end
  end

  initial begin
    rst_in = 1'b1;
    idle();
    cyc();
    get_id1 = 5'd5; get_id2 = 5'd0;
    expect_port(1, "reset_state", 32'h0, 1'b0, 4'd0, 4'd0);
    expect_port(2, "reset_state", 32'h0, 1'b0, 4'd0, 4'd0);

    cyc(); idle(); rst_in = 1'b0;
    set_dep_reg_id = 5'd5; set_dep_rob_id = 4'd3; get_id1 = 5'd5;
    expect_port(1, "dep_same_cycle_unseen", 32'h0, 1'b0, 4'd0, 4'd0);

    cyc(); idle(); get_id1 = 5'd5;
    expect_port(1, "pending_x5", 32'h0, 1'b1, 4'd3, 4'd3);

    cyc(); idle(); get_id1 = 5'd5; rob_value1_ready = 1'b1; rob_value1 = 32'hDEADBEEF;
    expect_port(1, "rob_forward", 32'hDEADBEEF, 1'b0, 4'd0, 4'd3);

    cyc(); idle();
    set_reg_id = 5'd5; set_val = 32'h12345678; set_reg_on_rob_id = 4'd3;
    get_id2 = 5'd5; get_id1 = 5'd5; rob_value1_ready = 1'b1; rob_value1 = 32'h0000CAFE;
    expect_port(2, "commit_bypass", 32'h12345678, 1'b0, 4'd0, 4'd3);
    expect_port(1, "bypass_over_rob", 32'h12345678, 1'b0, 4'd0, 4'd3);

    cyc(); idle(); get_id2 = 5'd5;
    expect_port(2, "committed_reg", 32'h12345678, 1'b0, 4'd0, 4'd3);

    cyc(); idle(); set_dep_reg_id = 5'd6; set_dep_rob_id = 4'd4;

    cyc(); idle();
    set_reg_id = 5'd6; set_val = 32'h0000AAAA; set_reg_on_rob_id = 4'd5; get_id1 = 5'd6;
    expect_port(1, "stale_commit_no_bypass", 32'h0, 1'b1, 4'd4, 4'd4);

    cyc(); idle(); get_id1 = 5'd6;
    expect_port(1, "stale_keeps_busy", 32'h0, 1'b1, 4'd4, 4'd4);

    cyc(); idle(); set_dep_reg_id = 5'd7; set_dep_rob_id = 4'd2;

    cyc(); idle();
    set_reg_id = 5'd7; set_val = 32'h00000077; set_reg_on_rob_id = 4'd2;
    set_dep_reg_id = 5'd7; set_dep_rob_id = 4'd9; get_id1 = 5'd7;
    expect_port(1, "commit_dep_bypass", 32'h00000077, 1'b0, 4'd0, 4'd2);

    cyc(); idle(); get_id1 = 5'd7;
    expect_port(1, "dep_wins", 32'h0, 1'b1, 4'd9, 4'd9);

    cyc(); idle(); set_dep_reg_id = 5'd1; set_dep_rob_id = 4'd1;
    cyc(); idle(); set_dep_reg_id = 5'd2; set_dep_rob_id = 4'd2;

    cyc(); idle();
    clear = 1'b1; set_reg_id = 5'd1; set_val = 32'h0000FFFF; set_reg_on_rob_id = 4'd1;
    set_dep_reg_id = 5'd3; set_dep_rob_id = 4'd5; get_id1 = 5'd1; get_id2 = 5'd2;
    expect_port(1, "clear_cycle_bypass", 32'h0000FFFF, 1'b0, 4'd0, 4'd1);
    expect_port(2, "clear_cycle_pending", 32'h0, 1'b1, 4'd2, 4'd2);

    cyc(); idle(); get_id1 = 5'd1; get_id2 = 5'd2;
    expect_port(1, "after_clear_x1", 32'h0, 1'b0, 4'd0, 4'd1);
    expect_port(2, "after_clear_x2", 32'h0, 1'b0, 4'd0, 4'd2);

    cyc(); idle(); get_id1 = 5'd3; get_id2 = 5'd6;
    expect_port(1, "clear_ignores_dep", 32'h0, 1'b0, 4'd0, 4'd0);
    expect_port(2, "stale_value_written", 32'h0000AAAA, 1'b0, 4'd0, 4'd4);

    cyc(); idle(); get_id1 = 5'd7; get_id2 = 5'd5;
    expect_port(1, "x7_value_kept", 32'h00000077, 1'b0, 4'd0, 4'd9);
    expect_port(2, "x5_value_kept", 32'h12345678, 1'b0, 4'd0, 4'd3);

    cyc(); idle();
    set_dep_reg_id = 5'd0; set_dep_rob_id = 4'd7;
    set_reg_id = 5'd0; set_val = 32'h00000055; set_reg_on_rob_id = 4'd7; get_id1 = 5'd0;
    expect_port(1, "x0_same_cycle", 32'h0, 1'b0, 4'd0, 4'd0);

    cyc(); idle(); get_id1 = 5'd0; get_id2 = 5'd0;
    expect_port(1, "x0_never_busy", 32'h0, 1'b0, 4'd0, 4'd0);
    expect_port(2, "x0_never_busy", 32'h0, 1'b0, 4'd0, 4'd0);

    cyc(); idle();
    rdy_in = 1'b0; set_dep_reg_id = 5'd8; set_dep_rob_id = 4'd3;
    set_reg_id = 5'd5; set_val = 32'h00000001; set_reg_on_rob_id = 4'd3; get_id2 = 5'd5;
    expect_port(2, "paused_read", 32'h12345678, 1'b0, 4'd0, 4'd3);

    cyc(); idle(); get_id1 = 5'd8; get_id2 = 5'd5;
    expect_port(1, "pause_no_dep", 32'h0, 1'b0, 4'd0, 4'd0);
    expect_port(2, "pause_no_commit", 32'h12345678, 1'b0, 4'd0, 4'd3);

    cyc(); idle(); set_dep_reg_id = 5'd9; set_dep_rob_id = 4'd6;

    cyc(); idle(); get_id1 = 5'd9; get_id2 = 5'd5;
    expect_port(1, "busy_before_reset", 32'h0, 1'b1, 4'd6, 4'd6);

    // Reset lands mid-cycle; the monitor samples before the next rising edge.
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    expect_port(1, "async_reset", 32'h0, 1'b0, 4'd0, 4'd0);
    expect_port(2, "async_reset", 32'h0, 1'b0, 4'd0, 4'd0);

    cyc(); rst_in = 1'b0;
    expect_port(1, "after_reset", 32'h0, 1'b0, 4'd0, 4'd0);
    expect_port(2, "after_reset", 32'h0, 1'b0, 4'd0, 4'd0);

    @(negedge clk_in); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
